// File: rtl/image_load_sequencer.sv
// Image load sequencer: reads BLOCKS_PER_IMAGE consecutive 512-byte SD blocks
// for the selected image slot and reports completion.
// Optional macro LOAD_TIMEOUT_EN adds a WAIT_DATA watchdog that aborts a
// stalled load with a one-cycle error pulse.
module image_load_sequencer #(
    parameter int unsigned BLOCKS_PER_IMAGE = 450,
    parameter logic [31:0] IMAGE_STRIDE     = 32'h00010000,
    parameter int unsigned TIMEOUT_CYCLES   = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  image_select,
    input  logic        load_req,
    input  logic        sd_ready,
    input  logic        sd_data_valid,
    output logic        sd_read_block,
    output logic [31:0] sd_block_addr,
    output logic        busy,
    output logic        done,
    output logic [8:0]  block_idx,
    output logic [8:0]  byte_idx,
    output logic [1:0]  loaded_slot,
    output logic        error
);

    localparam logic [8:0] LAST_BLOCK = 9'(BLOCKS_PER_IMAGE - 1);
    localparam logic [8:0] LAST_BYTE  = 9'd511;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DATA,
        NEXT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  slot_q, slot_d;
    logic [8:0]  block_idx_q, block_idx_d;
    logic [8:0]  byte_idx_q, byte_idx_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  loaded_slot_q, loaded_slot_d;
    logic        read_q, read_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [1:0]  sel_slot;

`ifdef LOAD_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_q, tmo_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    // Out-of-range selections fall back to slot 0
    assign sel_slot = (image_select < 4'd4) ? image_select[1:0] : 2'd0;

    function automatic logic [31:0] addr_of(input logic [1:0] slot, input logic [8:0] blk);
        return (32'(slot) * IMAGE_STRIDE) + 32'(blk);
    endfunction

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        block_idx_d   = block_idx_q;
        byte_idx_d    = byte_idx_q;
        addr_d        = addr_q;
        loaded_slot_d = loaded_slot_q;
        read_d        = 1'b0;
        done_d        = 1'b0;
        error_d       = 1'b0;
`ifdef LOAD_TIMEOUT_EN
        tmo_d         = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_req || (sel_slot != loaded_slot_q)) begin
                    slot_d      = sel_slot;
                    block_idx_d = 9'd0;
                    byte_idx_d  = 9'd0;
                    addr_d      = addr_of(sel_slot, 9'd0);
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (sd_ready) begin
                    read_d  = 1'b1;
                    state_d = WAIT_DATA;
`ifdef LOAD_TIMEOUT_EN
                    tmo_d   = 32'd0;
`endif
                end
            end
            WAIT_DATA: begin
                if (sd_data_valid) begin
`ifdef LOAD_TIMEOUT_EN
                    tmo_d = 32'd0;
`endif
                    if (byte_idx_q == LAST_BYTE) begin
                        byte_idx_d = 9'd0;
                        state_d    = NEXT;
                    end else begin
                        byte_idx_d = byte_idx_q + 9'd1;
                    end
                end
`ifdef LOAD_TIMEOUT_EN
                else if (tmo_q == TIMEOUT_LAST) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
`endif
            end
            NEXT: begin
                if (block_idx_q == LAST_BLOCK) begin
                    done_d        = 1'b1;
                    loaded_slot_d = slot_q;
                    state_d       = DONE;
                end else begin
                    block_idx_d = block_idx_q + 9'd1;
                    addr_d      = addr_of(slot_q, block_idx_q + 9'd1);
                    state_d     = ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == ISSUE) || (state_d == WAIT_DATA) || (state_d == NEXT);
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            slot_q        <= 2'd0;
            block_idx_q   <= 9'd0;
            byte_idx_q    <= 9'd0;
            addr_q        <= 32'd0;
            loaded_slot_q <= 2'd0;
            read_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            tmo_q         <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            block_idx_q   <= block_idx_d;
            byte_idx_q    <= byte_idx_d;
            addr_q        <= addr_d;
            loaded_slot_q <= loaded_slot_d;
            read_q        <= read_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
`ifdef LOAD_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign sd_read_block = read_q;
    assign sd_block_addr = addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign block_idx     = block_idx_q;
    assign byte_idx      = byte_idx_q;
    assign loaded_slot   = loaded_slot_q;
    assign error         = error_q;

endmodule

// File: tb/tb_image_load_sequencer.sv
// Scoreboard bench for image_load_sequencer with a two-block image.
module tb_image_load_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  image_select = 4'd0;
    logic        load_req = 1'b0;
    logic        sd_ready = 1'b1;
    logic        sd_data_valid = 1'b0;
    logic        sd_read_block;
    logic [31:0] sd_block_addr;
    logic        busy;
    logic        done;
    logic [8:0]  block_idx;
    logic [8:0]  byte_idx;
    logic [1:0]  loaded_slot;
    logic        error;

    int vectors = 0;
    int miscompares = 0;
    int errors_seen = 0;
    logic [31:0] exp_addr_q[$];
    logic [1:0]  exp_slot_q[$];
    logic prev_rd = 1'b0;
    logic prev_done = 1'b0;

    image_load_sequencer #(
        .BLOCKS_PER_IMAGE(2),
        .IMAGE_STRIDE(32'h00010000),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .reset(reset),
        .image_select(image_select),
        .load_req(load_req),
        .sd_ready(sd_ready),
        .sd_data_valid(sd_data_valid),
        .sd_read_block(sd_read_block),
        .sd_block_addr(sd_block_addr),
        .busy(busy),
        .done(done),
        .block_idx(block_idx),
        .byte_idx(byte_idx),
        .loaded_slot(loaded_slot),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input int n);
        sd_data_valid = 1'b1;
        repeat (n) tick();
        sd_data_valid = 1'b0;
    endtask

    task automatic wait_strobe(input string name);
        int k;
        k = 0;
        while (!sd_read_block && k < 20) begin
            tick();
            k++;
        end
        if (!sd_read_block) fail_now({name, "_strobe_timeout"});
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 20) begin
            tick();
            k++;
        end
        if (!done) fail_now({name, "_done_timeout"});
    endtask

    task automatic run_block(input string name, input logic [8:0] b);
        wait_strobe(name);
        check({name, "_block_idx"}, 32'(block_idx), 32'(b));
        send_bytes(512);
    endtask

    // Monitor: every strobe and done pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            prev_rd   <= 1'b0;
            prev_done <= 1'b0;
        end else begin
            if (sd_read_block) begin
                if (prev_rd) fail_now("strobe_width");
                if (exp_addr_q.size() == 0) fail_now("unexpected_strobe");
                else check("strobe_addr", sd_block_addr, exp_addr_q.pop_front());
            end
            if (done) begin
                if (prev_done) fail_now("done_width");
                check("done_busy", 32'(busy), 32'd0);
                if (exp_slot_q.size() == 0) fail_now("unexpected_done");
                else check("done_loaded_slot", 32'(loaded_slot), 32'(exp_slot_q.pop_front()));
            end
            if (error) errors_seen++;
            prev_rd   <= sd_read_block;
            prev_done <= done;
        end
    end

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_read", 32'(sd_read_block), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_block_idx", 32'(block_idx), 32'd0);
        check("rst_byte_idx", 32'(byte_idx), 32'd0);
        check("rst_addr", sd_block_addr, 32'd0);
        check("rst_loaded", 32'(loaded_slot), 32'd0);
        reset = 1'b0;

        // Idle with matching selection: no load, stray data ignored
        sd_data_valid = 1'b1;
        repeat (5) tick();
        sd_data_valid = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_byte_idx", 32'(byte_idx), 32'd0);

        // Basic two-block load of slot 2
        exp_addr_q.push_back(32'h00020000);
        exp_addr_q.push_back(32'h00020001);
        exp_slot_q.push_back(2'd2);
        image_select = 4'd2;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check("l2_busy_issue", 32'(busy), 32'd1);
        wait_strobe("l2_b0");
        check("l2_block0", 32'(block_idx), 32'd0);
        send_bytes(300);
        check("l2_byte300", 32'(byte_idx), 32'd300);
        send_bytes(212);
        check("l2_byte_wrap", 32'(byte_idx), 32'd0);
        run_block("l2_b1", 9'd1);
        wait_done("l2");
        tick();
        check("l2_done_cleared", 32'(done), 32'd0);
        check("l2_idle_busy", 32'(busy), 32'd0);

        // sd_ready held low in ISSUE: no strobe, busy stays high
        sd_ready = 1'b0;
        exp_addr_q.push_back(32'h00020000);
        exp_addr_q.push_back(32'h00020001);
        exp_slot_q.push_back(2'd2);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        sd_data_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stall_no_strobe", 32'(sd_read_block), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        check("stall_byte_idx", 32'(byte_idx), 32'd0);
        sd_data_valid = 1'b0;
        sd_ready = 1'b1;
        tick();
        check("stall_strobe_after_ready", 32'(sd_read_block), 32'd1);
        send_bytes(512);
        run_block("stall_b1", 9'd1);
        wait_done("stall");
        tick();

        // Selection change mid-block is deferred, then auto-reload
        exp_addr_q.push_back(32'h00010000);
        exp_addr_q.push_back(32'h00010001);
        exp_addr_q.push_back(32'h00030000);
        exp_addr_q.push_back(32'h00030001);
        exp_slot_q.push_back(2'd1);
        exp_slot_q.push_back(2'd3);
        image_select = 4'd1;
        tick();
        wait_strobe("sw_b0");
        send_bytes(200);
        image_select = 4'd3;
        send_bytes(312);
        run_block("sw_b1", 9'd1);
        wait_done("sw1");
        tick();
        run_block("sw3_b0", 9'd0);
        run_block("sw3_b1", 9'd1);
        wait_done("sw3");
        tick();

        // Reset mid-load abandons the load silently
        exp_addr_q.push_back(32'h00030000);
        exp_addr_q.push_back(32'h00030001);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        run_block("rm_b0", 9'd0);
        wait_strobe("rm_b1");
        send_bytes(300);
        check("rm_byte300", 32'(byte_idx), 32'd300);
        check("rm_block1", 32'(block_idx), 32'd1);
        reset = 1'b1;
        tick();
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_block_idx", 32'(block_idx), 32'd0);
        check("rm_byte_idx", 32'(byte_idx), 32'd0);
        check("rm_done", 32'(done), 32'd0);
        check("rm_error", 32'(error), 32'd0);
        check("rm_loaded", 32'(loaded_slot), 32'd0);
        tick();
        check("rm_hold_busy", 32'(busy), 32'd0);
        exp_addr_q.push_back(32'h00030000);
        exp_addr_q.push_back(32'h00030001);
        exp_slot_q.push_back(2'd3);
        reset = 1'b0;
        tick();
        check("rm_restart_busy", 32'(busy), 32'd1);
        run_block("rr_b0", 9'd0);
        run_block("rr_b1", 9'd1);
        wait_done("rr");
        tick();

        // No data after the strobe
        exp_addr_q.push_back(32'h00030000);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        wait_strobe("to");
        repeat (60) tick();
`ifdef LOAD_TIMEOUT_EN
        check("to_busy", 32'(busy), 32'd0);
        check("to_loaded", 32'(loaded_slot), 32'd3);
        check("to_error_count", 32'(errors_seen), 32'd1);
`else
        check("to_busy", 32'(busy), 32'd1);
        check("to_byte_idx", 32'(byte_idx), 32'd0);
        check("to_error_count", 32'(errors_seen), 32'd0);
`endif
        check("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
        check("slot_queue_empty", 32'(exp_slot_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/image_load_sequencer.md
IMAGE_LOAD_SEQUENCER -- requirements
Module: image_load_sequencer

Interface
REQ-001 SHALL have parameter BLOCKS_PER_IMAGE, default 450, number of 512-byte SD blocks per 320x240x24-bit image.
REQ-002 SHALL have parameter IMAGE_STRIDE, default 32'h00010000, block-address distance between consecutive image slots.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, watchdog limit (used only under REQ-029).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port image_select  input  4  requested image slot; 0..3 valid, others map to slot 0.
REQ-007 SHALL have port load_req  input  1  single-cycle request to (re)load the selected image.
REQ-008 SHALL have port sd_ready  input  1  SD controller idle and able to accept a block read.
REQ-009 SHALL have port sd_data_valid  input  1  one data byte delivered by the SD controller this cycle.
REQ-010 SHALL have port sd_read_block  output  1  single-cycle block-read strobe to the SD controller.
REQ-011 SHALL have port sd_block_addr  output  32  block address for the current read.
REQ-012 SHALL have port busy  output  1  high while a load is in progress.
REQ-013 SHALL have port done  output  1  single-cycle pulse on successful image load.
REQ-014 SHALL have port block_idx  output  9  index of the block being read within the image (0..BLOCKS_PER_IMAGE-1).
REQ-015 SHALL have port byte_idx  output  9  index of the next expected byte within the current block (0..511).
REQ-016 SHALL have port loaded_slot  output  2  slot of the last image successfully loaded.
REQ-017 SHALL have port error  output  1  single-cycle pulse on aborted load (tied 0 when REQ-029 is compiled out).

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT_DATA, NEXT, DONE.
REQ-019 IDLE: a load SHALL start on load_req=1, or when the mapped image_select differs from loaded_slot; the mapped slot is latched, block_idx=0, byte_idx=0, next state ISSUE.
REQ-020 ISSUE: SHALL wait for sd_ready=1, then assert sd_read_block for exactly one cycle and enter WAIT_DATA on the following cycle.
REQ-021 sd_block_addr SHALL equal latched_slot*IMAGE_STRIDE + block_idx, 32-bit unsigned, stable from ISSUE until leaving WAIT_DATA.
REQ-022 WAIT_DATA: each sd_data_valid SHALL increment byte_idx; the byte with byte_idx=511 SHALL wrap byte_idx to 0 and enter NEXT.
REQ-023 NEXT (one cycle): if block_idx==BLOCKS_PER_IMAGE-1, go to DONE; otherwise increment block_idx and go to ISSUE.
REQ-024 DONE (one cycle): done=1, loaded_slot=latched slot, then IDLE.
REQ-025 sd_data_valid outside WAIT_DATA SHALL be ignored; byte_idx unchanged.
REQ-026 load_req and image_select changes while busy SHALL be ignored; the in-flight load completes with the latched slot, and a differing selection triggers a new load from IDLE per REQ-019.
REQ-027 busy SHALL be 1 in ISSUE, WAIT_DATA and NEXT; 0 in IDLE and DONE.

Reset
REQ-028 On reset SHALL enter IDLE with sd_read_block=0, busy=0, done=0, error=0, block_idx=0, byte_idx=0, sd_block_addr=0, loaded_slot=0; reset mid-load SHALL abandon the load without asserting done or error, and no load starts until the cycle after reset deasserts.

Configuration
REQ-029 Macro LOAD_TIMEOUT_EN: when defined, a counter SHALL clear on entry to WAIT_DATA and on every sd_data_valid; if it reaches TIMEOUT_CYCLES, error SHALL pulse for one cycle, state SHALL return to IDLE, and loaded_slot SHALL be unchanged. When undefined, WAIT_DATA waits indefinitely and error is constant 0.

Verification
REQ-030 BLOCKS_PER_IMAGE=2, reset then load_req with image_select=2 and sd_ready=1 -> one sd_read_block pulse with sd_block_addr=32'h00020000; after 512 bytes a second pulse with address 32'h00020001; after 512 more bytes done=1 for one cycle, loaded_slot=2.
REQ-031 sd_ready=0 for 20 cycles in ISSUE -> no sd_read_block strobe; strobe occurs in the cycle after sd_ready rises, busy=1 throughout.
REQ-032 image_select changes 1->3 mid-block -> addresses continue with slot 1 until done; IDLE then auto-starts a load at 32'h00030000.
REQ-033 reset asserted at byte_idx=300 of block 1 -> next cycle busy=0, block_idx=0, byte_idx=0, no done or error pulse.
REQ-034 LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=50, no sd_data_valid after strobe -> error pulses exactly once, state IDLE, loaded_slot unchanged; without the macro the block remains in WAIT_DATA with busy=1.
